// File: rtl/fifo_read_arbiter.sv
// Round-robin read arbiter draining CHANNELS FWFT FIFOs into one registered valid/ready stream.
// Define FIFO_READ_ARBITER_BURST_EN to let a channel keep the grant for up to BURST_LENGTH words.
module fifo_read_arbiter #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned BURST_LENGTH  = 4,
  parameter int unsigned CHANNELS_LOG2 = $clog2(CHANNELS)
) (
  input  logic                      i_clock,
  input  logic                      i_resetn,
  input  logic [CHANNELS-1:0]       i_fifo_empty,
  output logic [CHANNELS-1:0]       o_fifo_read_enable,
  input  logic [CHANNELS*WIDTH-1:0] i_fifo_read_data,
  output logic                      o_output_valid,
  input  logic                      i_output_ready,
  output logic [WIDTH-1:0]          o_output_data,
  output logic [CHANNELS_LOG2-1:0]  o_output_channel
);

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [CHANNELS_LOG2-1:0] r_last_grant;
  logic [CHANNELS_LOG2-1:0] r_channel;
  logic [WIDTH-1:0]         r_data;
  logic [CHANNELS_LOG2-1:0] w_rr_grant;
  logic                     w_rr_valid;
  logic [CHANNELS_LOG2-1:0] w_grant;
  logic                     w_grant_valid;
  logic [WIDTH-1:0]         w_grant_data;
  logic                     w_load;

  if (CHANNELS < 2 || BURST_LENGTH < 1) begin : g_bad_params
    $error("fifo_read_arbiter: CHANNELS must be >= 2 and BURST_LENGTH >= 1");
  end

  // First non-empty channel after the last grant, wrapping without a modulo.
  always_comb begin : p_rr_search
    int unsigned idx;
    idx        = 0;
    w_rr_grant = '0;
    w_rr_valid = 1'b0;
    for (int unsigned i = 1; i <= CHANNELS; i++) begin
      idx = 32'(r_last_grant) + i;
      if (idx >= CHANNELS) begin
        idx = idx - CHANNELS;
      end
      if (!w_rr_valid && !i_fifo_empty[CHANNELS_LOG2'(idx)]) begin
        w_rr_grant = CHANNELS_LOG2'(idx);
        w_rr_valid = 1'b1;
      end
    end
  end

`ifdef FIFO_READ_ARBITER_BURST_EN
  localparam int unsigned BCNT_W = $clog2(BURST_LENGTH + 1);

  logic [BCNT_W-1:0] r_burst_cnt;
  logic              w_hold;

  // A zero count means no grant has been issued yet, so nothing is held.
  assign w_hold = (r_burst_cnt != '0) && (r_burst_cnt < BCNT_W'(BURST_LENGTH)) &&
                  !i_fifo_empty[r_last_grant];
  assign w_grant       = w_hold ? r_last_grant : w_rr_grant;
  assign w_grant_valid = w_hold || w_rr_valid;

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_burst_cnt <= '0;
    end else if (w_load) begin
      r_burst_cnt <= w_hold ? r_burst_cnt + BCNT_W'(1) : BCNT_W'(1);
    end
  end
`else
  assign w_grant       = w_rr_grant;
  assign w_grant_valid = w_rr_valid;
`endif

  // Head word of the granted channel.
  always_comb begin
    w_grant_data = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (w_grant == CHANNELS_LOG2'(c)) begin
        w_grant_data = i_fifo_read_data[c*WIDTH +: WIDTH];
      end
    end
  end

  // Reset gates the pop so nothing is read while the register is being cleared.
  assign w_load = i_resetn && w_grant_valid && (!o_output_valid || i_output_ready);

  always_comb begin
    w_state_next       = r_state;
    o_fifo_read_enable = '0;
    if (w_load) begin
      o_fifo_read_enable[w_grant] = 1'b1;
    end
    case (r_state)
      ST_EMPTY: begin
        if (w_load) begin
          w_state_next = ST_LOADED;
        end
      end
      ST_LOADED: begin
        if (!w_load && i_output_ready) begin
          w_state_next = ST_EMPTY;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_data       <= '0;
      r_channel    <= '0;
      r_last_grant <= CHANNELS_LOG2'(CHANNELS - 1);
    end else if (w_load) begin
      r_data       <= w_grant_data;
      r_channel    <= w_grant;
      r_last_grant <= w_grant;
    end
  end

  assign o_output_valid   = (r_state == ST_LOADED);
  assign o_output_data    = r_data;
  assign o_output_channel = r_channel;

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Directed bench for fifo_read_arbiter: a 4-channel instance fed by FIFO models and a 3-channel instance.
module tb_fifo_read_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        ready;
  logic [3:0]  empty;
  logic [3:0]  re;
  logic [31:0] rdata;
  logic        valid;
  logic [7:0]  odata;
  logic [1:0]  och;

  logic [2:0]  e3;
  logic [2:0]  re3;
  logic [23:0] d3;
  logic        ready3;
  logic        valid3;
  logic [7:0]  odata3;
  logic [1:0]  och3;

  fifo_read_arbiter #(.CHANNELS(4), .WIDTH(8), .BURST_LENGTH(4)) u_dut4 (
    .i_clock(clk), .i_resetn(resetn), .i_fifo_empty(empty), .o_fifo_read_enable(re),
    .i_fifo_read_data(rdata), .o_output_valid(valid), .i_output_ready(ready),
    .o_output_data(odata), .o_output_channel(och));

  fifo_read_arbiter #(.CHANNELS(3), .WIDTH(8), .BURST_LENGTH(4)) u_dut3 (
    .i_clock(clk), .i_resetn(resetn), .i_fifo_empty(e3), .o_fifo_read_enable(re3),
    .i_fifo_read_data(d3), .o_output_valid(valid3), .i_output_ready(ready3),
    .o_output_data(odata3), .o_output_channel(och3));

  assign d3 = {8'hC2, 8'hC1, 8'hC0};

  // FWFT FIFO models for the 4-channel instance
  logic [7:0]  mem [4][32];
  int unsigned wr_n [4] = '{default: 0};
  int unsigned rd_p [4] = '{default: 0};

  always_comb begin
    empty = '1;
    rdata = '0;
    for (int c = 0; c < 4; c++) begin
      empty[c]         = (rd_p[c] == wr_n[c]);
      rdata[c*8 +: 8]  = mem[c][rd_p[c][4:0]];
    end
  end

  always @(posedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (re[c]) rd_p[c] <= rd_p[c] + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [7:0] d);
    mem[c][wr_n[c][4:0]] = d;
    wr_n[c] = wr_n[c] + 1;
  endtask

  task automatic drain();
    ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      #1;
      if (empty == 4'hF && !valid) break;
    end
    chk("drain_done", {27'd0, empty, valid}, {27'd0, 4'hF, 1'b0});
  endtask

  // Read enables must be one-hot-or-zero, never target an empty FIFO, and never fire while stalled.
  always @(negedge clk) begin
    #2;
    if (resetn) begin
      checks++;
      if (!$onehot0(re) || ((re & empty) != 4'd0) || (valid && !ready && re != 4'd0)) begin
        errors++;
        $display("FAIL re_legal4: re=%b empty=%b valid=%b ready=%b", re, empty, valid, ready);
      end
      checks++;
      if (!$onehot0(re3) || ((re3 & e3) != 3'd0) || (valid3 && !ready3 && re3 != 3'd0)) begin
        errors++;
        $display("FAIL re_legal3: re=%b empty=%b valid=%b ready=%b", re3, e3, valid3, ready3);
      end
    end
  end

  typedef struct {
    logic       exp_valid;
    logic [1:0] exp_ch;
    logic [7:0] exp_data;
  } vec_t;

  vec_t       t1 [9];
  vec_t       t4 [7];
  logic [2:0] t6 [5];
  logic [7:0] t3_next;
  logic [7:0] t5_head;

  initial begin
    // Expected tables
    for (int i = 0; i < 8; i++) begin
      int c;
      int k;
`ifdef FIFO_READ_ARBITER_BURST_EN
      c = i / 2;
      k = i % 2;
`else
      c = i % 4;
      k = i / 4;
`endif
      t1[i] = '{1'b1, 2'(c), 8'(16 * c + k)};
    end
    t1[8] = '{1'b0, 2'd0, 8'h00};
`ifdef FIFO_READ_ARBITER_BURST_EN
    t4 = '{'{1'b1, 2'd1, 8'h60}, '{1'b1, 2'd1, 8'h61}, '{1'b1, 2'd1, 8'h62},
           '{1'b1, 2'd1, 8'h63}, '{1'b1, 2'd3, 8'h7A}, '{1'b1, 2'd1, 8'h64},
           '{1'b1, 2'd1, 8'h65}};
    t6 = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010};
    t3_next = 8'h41;
    t5_head = 8'h82;
`else
    t4 = '{'{1'b1, 2'd1, 8'h60}, '{1'b1, 2'd3, 8'h7A}, '{1'b1, 2'd1, 8'h61},
           '{1'b1, 2'd1, 8'h62}, '{1'b1, 2'd1, 8'h63}, '{1'b1, 2'd1, 8'h64},
           '{1'b1, 2'd1, 8'h65}};
    t6 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    t3_next = 8'h50;
    t5_head = 8'h81;
`endif

    // Reset values, then two words per channel streamed at full rate
    ready  = 1'b1;
    ready3 = 1'b0;
    e3     = 3'b111;
    resetn = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_data", {24'd0, odata}, 32'd0);
    chk("rst_channel", {30'd0, och}, 32'd0);
    chk("rst_re", {28'd0, re}, 32'd0);
    chk("rst_valid3", {31'd0, valid3}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 2; k++) push(c, 8'(16 * c + k));
    end
    #1;
    chk("rst_re_held_low", {28'd0, re}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("t1_valid[%0d]", i), {31'd0, valid}, {31'd0, t1[i].exp_valid});
      if (t1[i].exp_valid) begin
        chk($sformatf("t1_ch[%0d]", i), {30'd0, och}, {30'd0, t1[i].exp_ch});
        chk($sformatf("t1_data[%0d]", i), {24'd0, odata}, {24'd0, t1[i].exp_data});
      end
    end

    // Single active channel: eligible in the cycle it fills, valid drops after its last word
    @(negedge clk);
    push(2, 8'hA0);
    push(2, 8'hA1);
    push(2, 8'hA2);
    #1;
    chk("t2_eligible_re", {28'd0, re}, 32'h4);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("t2_valid[%0d]", k), {31'd0, valid}, 32'd1);
      chk($sformatf("t2_ch[%0d]", k), {30'd0, och}, 32'd2);
      chk($sformatf("t2_data[%0d]", k), {24'd0, odata}, 32'hA0 + 32'(k));
    end
    @(negedge clk);
    #1;
    chk("t2_valid_drop", {31'd0, valid}, 32'd0);

    // Consumer stall with every channel non-empty
    ready  = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 2; k++) push(c, 8'(16 * (c + 4) + k));
    end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("t3_first_re", {28'd0, re}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("t3_stall_valid[%0d]", i), {31'd0, valid}, 32'd1);
      chk($sformatf("t3_stall_data[%0d]", i), {24'd0, odata}, 32'h40);
      chk($sformatf("t3_stall_ch[%0d]", i), {30'd0, och}, 32'd0);
      chk($sformatf("t3_stall_re[%0d]", i), {28'd0, re}, 32'd0);
    end
    @(negedge clk);
    ready = 1'b1;
    #1;
    chk("t3_release_re", {28'd0, re}, (t3_next == 8'h50) ? 32'h2 : 32'h1);
    @(negedge clk);
    #1;
    chk("t3_next_valid", {31'd0, valid}, 32'd1);
    chk("t3_next_data", {24'd0, odata}, {24'd0, t3_next});
    chk("t3_next_ch", {30'd0, och}, {30'd0, t3_next[4] ? 2'd1 : 2'd0});
    drain();

    // Channel 3 arrives while channel 1 is streaming
    resetn = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 6; k++) push(1, 8'h60 + 8'(k));
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 0) push(3, 8'h7A);
      #1;
      chk($sformatf("t4_valid[%0d]", i), {31'd0, valid}, 32'd1);
      chk($sformatf("t4_ch[%0d]", i), {30'd0, och}, {30'd0, t4[i].exp_ch});
      chk($sformatf("t4_data[%0d]", i), {24'd0, odata}, {24'd0, t4[i].exp_data});
    end
    @(negedge clk);
    #1;
    chk("t4_valid_drop", {31'd0, valid}, 32'd0);

    // Asynchronous reset while a word is held
    resetn = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      push(0, 8'h80 + 8'(k));
      push(1, 8'h90 + 8'(k));
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("t5_valid_before", {31'd0, valid}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("t5_rst_valid", {31'd0, valid}, 32'd0);
    chk("t5_rst_re", {28'd0, re}, 32'd0);
    chk("t5_rst_data", {24'd0, odata}, 32'd0);
    chk("t5_rst_ch", {30'd0, och}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("t5_first_re", {28'd0, re}, 32'h1);
    @(negedge clk);
    #1;
    chk("t5_first_valid", {31'd0, valid}, 32'd1);
    chk("t5_first_ch", {30'd0, och}, 32'd0);
    chk("t5_first_data", {24'd0, odata}, {24'd0, t5_head});
    drain();

    // Three channels, all permanently non-empty: index wraps 2 -> 0
    resetn = 1'b0;
    ready3 = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    e3     = 3'b000;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk($sformatf("t6_re3[%0d]", i), {29'd0, re3}, {29'd0, t6[i]});
      if (i > 0) begin
        logic [1:0] g;
        g = (t6[i-1] == 3'b001) ? 2'd0 : (t6[i-1] == 3'b010) ? 2'd1 : 2'd2;
        chk($sformatf("t6_ch3[%0d]", i), {30'd0, och3}, {30'd0, g});
        chk($sformatf("t6_data3[%0d]", i), {24'd0, odata3}, 32'hC0 + 32'(g));
      end
    end
    e3 = 3'b111;
    @(negedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
